// File: rtl/mips32_pkg.sv
// Shared MIPS32 datapath constants and types for the writeback/register-file slice.
package mips32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/wb_mux.sv
// Writeback select: load data when sel_load_i is set, otherwise the ALU result.
module wb_mux #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              sel_load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic [DATA_W-1:0] wdata_o
);

    always_comb begin
        wdata_o = sel_load_i ? load_data_i : alu_result_i;
    end

endmodule

// File: rtl/wb_register_file.sv
// MIPS32 register file with writeback mux and committed-write counter.
// Define WB_REGFILE_BYPASS_EN to forward a same-cycle write to the read ports.
module wb_register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              RegWrite_WB,
    input  logic              MemtoReg_WB,
    input  logic [DATA_W-1:0] Read_Data_WB,
    input  logic [DATA_W-1:0] ALU_Result_WB,
    input  logic [ADDR_W-1:0] Write_Register_WB,
    input  logic [ADDR_W-1:0] Read_Register_1,
    input  logic [ADDR_W-1:0] Read_Register_2,
    output logic [DATA_W-1:0] Read_Data_1,
    output logic [DATA_W-1:0] Read_Data_2,
    output logic [DATA_W-1:0] Write_Data_WB,
    output logic [15:0]       Write_Count
);

    import mips32_pkg::*;

    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IdxZero = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [1:NumRegs-1];
    logic [DATA_W-1:0] regs_d [1:NumRegs-1];
    logic [15:0]       count_q, count_d;
    logic              armed_q, armed_d;
    logic              commit;

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .sel_load_i   (MemtoReg_WB),
        .load_data_i  (Read_Data_WB),
        .alu_result_i (ALU_Result_WB),
        .wdata_o      (Write_Data_WB)
    );

    // armed_q stays low through the first edge after reset release, so a write
    // presented on that edge is dropped.
    always_comb begin
        commit = armed_q && RegWrite_WB && (Write_Register_WB != IdxZero);
    end

    always_comb begin
        regs_d  = regs_q;
        count_d = count_q;
        armed_d = 1'b1;
        if (commit) begin
            regs_d[Write_Register_WB] = Write_Data_WB;
            count_d                   = count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 1; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
            armed_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        Read_Data_1 = '0;
        Read_Data_2 = '0;
        if (Reset_n) begin
            if (Read_Register_1 != IdxZero) begin
                Read_Data_1 = regs_q[Read_Register_1];
            end
            if (Read_Register_2 != IdxZero) begin
                Read_Data_2 = regs_q[Read_Register_2];
            end
`ifdef WB_REGFILE_BYPASS_EN
            if (commit && (Write_Register_WB == Read_Register_1)) begin
                Read_Data_1 = Write_Data_WB;
            end
            if (commit && (Write_Register_WB == Read_Register_2)) begin
                Read_Data_2 = Write_Data_WB;
            end
`endif
        end
    end

    always_comb begin
        Write_Count = count_q;
    end

endmodule
